reg_rename_file: RTL and testbench
==================================

# reg_rename_file

Parametrised architectural register file with per-register rename tags, used between dispatcher and reorder buffer. It holds committed values, plus a busy bit and ROB tag per register. It serves NRD independent read ports with optional same-cycle commit bypass. It also supports single-cycle flush of all rename state on mispredict rollback, and keeps a registered count of busy registers for dispatcher stall heuristics.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, architectural register count (power of two, ≥2); RW = clog2(NREG)
- ROB_W, 4, ROB tag width
- NRD, 2, number of read ports (≥1)

Ports:
- clk_in  in  1  clock; all state updates on rising edge
- rst_n_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global ready; low freezes all state
- disp_en_in  in  1  dispatch rename request valid
- disp_rd_in  in  RW  destination register being renamed
- disp_tag_in  in  ROB_W  ROB tag assigned to that destination
- rs_in  in  NRD*RW  read register index, port p at [p*RW +: RW]
- val_out  out  NRD*XLEN  read value per port
- busy_out  out  NRD  read register has pending producer
- tag_out  out  NRD*ROB_W  producer tag per port; 0 when not busy
- com_en_in  in  1  ROB commit valid
- com_rd_in  in  RW  committed destination
- com_val_in  in  XLEN  committed value
- com_tag_in  in  ROB_W  tag of committing entry
- flush_in  in  1  rollback: clear all rename state
- busy_cnt_out  out  clog2(NREG)+1  registered number of busy registers

## Operation
- Register 0 handling:
  - Writes, dispatch renames and commits to x0 are ignored.
  - Reads of x0 return val 0, busy 0, tag 0 on every port, regardless of bypass.
- Reads are combinational from current state.
  - Reads show the mapping *before* this cycle's dispatch, so an instruction renaming rd == rs sees the old producer.
  - Reads never bypass dispatch.
- Edge update, when rdy_in = 1:
  - Commit value write: com_en_in and com_rd_in ≠ 0 → value[com_rd_in] <= com_val_in.
  - Commit busy clear: com_en_in, busy[com_rd_in], tag[com_rd_in] == com_tag_in → busy <= 0, tag <= 0. A tag mismatch leaves rename state untouched (a younger producer exists).
  - Dispatch: disp_en_in and disp_rd_in ≠ 0 → busy <= 1, tag <= disp_tag_in. This overrides a same-register commit clear in the same cycle.
  - Flush: all busy <= 0, all tags <= 0, busy count <= 0.
    - Flush drops a same-cycle dispatch.
    - Flush does not block a same-cycle commit value write.
  - busy_cnt_out tracks popcount(busy) incrementally:
    - +1 when dispatch sets a previously idle register.
    - −1 when commit clears one.
    - Net 0 when dispatch re-renames a busy register or when commit and dispatch hit the same register.
- rdy_in = 0: no state change; outputs still track rs_in combinationally.
- Reset: all values, busy bits, tags and busy_cnt_out become 0 immediately on rst_n_in falling. While rst_n_in is low, val_out, busy_out and tag_out are forced to 0.

## Timing
- Read latency 0 cycles (combinational rs_in → outputs).
- Dispatch visible on reads the cycle after the enabling edge.
- Commit visible on reads:
  - the cycle after the edge, or
  - the same cycle when bypass is compiled in.
- Flush effective the cycle after the edge; the flush cycle itself still reads old state.
- busy_cnt_out is registered: it reflects edge N updates in cycle N+1.
- Reset release is synchronised by the top level; the block needs no extra recovery cycle.

## Configuration
- REGFILE_COMMIT_BYPASS_EN defined:
  - A read port whose rs matches com_rd_in (≠ 0) with com_en_in high returns com_val_in.
  - If that register is busy with tag == com_tag_in, the port also reports busy 0, tag 0, in the same cycle.
  - Bypass applies even when rdy_in is low.
- Undefined: reads show registered state only. The dispatcher must catch commit/CDB broadcasts itself.

## Structure
- Shared package/header defines:
  - data, register-index and ROB-tag widths and types
  - reset constants: data 0, tag 0, reg 0
- Sub-module reg_read_port is instantiated NRD times. It contains the x0 forcing and the bypass mux over state arrays plus the commit inputs.
- State arrays, update logic and busy counter live in the top module.

## Test plan
- Reset, then read x5 on both ports → val 0, busy 0, tag 0, busy_cnt_out 0.
- Dispatch x5 tag 3; next cycle read x5 → busy 1, tag 3, busy_cnt_out 1. The same-cycle read during dispatch → busy 0.
- Dispatch x5 tag 3, then tag 7; commit x5 tag 3 val 0xAA → x5 val 0xAA, busy 1, tag 7, count 1. Then commit tag 7 val 0xBB → busy 0, val 0xBB, count 0.
- With REGFILE_COMMIT_BYPASS_EN: x6 busy tag 2; in the commit cycle of x6 tag 2 val 0x1234, port 1 reads x6 → val 0x1234, busy 0. Without the macro → old val, busy 1.
- Rename x1, x2, x3 (count 3); flush with simultaneous dispatch x4 and commit x1 val 9 → next cycle all busy 0, count 0, x1 val 9, x4 idle.
- Dispatch and commit to x0, then read x0 → 0/0/0, count unchanged. Assert rst_n_in mid-stream → outputs 0 immediately, state cleared.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// Shared widths, types and reset constants for the rename register file.
// Optional feature: REGFILE_COMMIT_BYPASS_EN (see reg_read_port).
package reg_rename_file_pkg;

   // Default geometry; instances may override through parameters.
   localparam int unsigned DefXlen  = 32;
   localparam int unsigned DefNreg  = 32;
   localparam int unsigned DefRobW  = 4;
   localparam int unsigned DefRegW  = $clog2(DefNreg);

   typedef logic [DefXlen-1:0] data_t;
   typedef logic [DefRegW-1:0] reg_idx_t;
   typedef logic [DefRobW-1:0] rob_tag_t;

   // Reset / idle values, cast to the instance width at the point of use.
   localparam int unsigned DataRst = 0;
   localparam int unsigned TagRst  = 0;
   localparam int unsigned RegZero = 0;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: x0 forcing, reset forcing and the optional
// same-cycle commit bypass (compiled in with REGFILE_COMMIT_BYPASS_EN).
module reg_read_port
   import reg_rename_file_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREG  = 32,
   parameter int unsigned ROB_W = 4,
   parameter int unsigned RW    = $clog2(NREG)
) (
   input  logic             rst_n_in,
   input  logic [RW-1:0]    rs_in,
   input  logic [XLEN-1:0]  vals_in [NREG],
   input  logic [NREG-1:0]  busy_in,
   input  logic [ROB_W-1:0] tags_in [NREG],
   input  logic             com_en_in,
   input  logic [RW-1:0]    com_rd_in,
   input  logic [XLEN-1:0]  com_val_in,
   input  logic [ROB_W-1:0] com_tag_in,
   output logic [XLEN-1:0]  val_out,
   output logic             busy_out,
   output logic [ROB_W-1:0] tag_out
);

`ifndef REGFILE_COMMIT_BYPASS_EN
   // Commit inputs only matter when the bypass is compiled in.
   logic unused_com;
   assign unused_com = ^{com_en_in, com_rd_in, com_val_in, com_tag_in};
`endif

   // Select registered state, optionally overlay the commit, then force x0/reset.
   always_comb begin
      val_out  = vals_in[rs_in];
      busy_out = busy_in[rs_in];
      tag_out  = tags_in[rs_in];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (com_en_in && (com_rd_in == rs_in)) begin
         val_out = com_val_in;
         // Only the matching producer retires; a younger rename stays visible.
         if (busy_in[rs_in] && (tags_in[rs_in] == com_tag_in)) begin
            busy_out = 1'b0;
            tag_out  = ROB_W'(TagRst);
         end
      end
`endif
      if (!rst_n_in || (rs_in == RW'(RegZero))) begin
         val_out  = XLEN'(DataRst);
         busy_out = 1'b0;
         tag_out  = ROB_W'(TagRst);
      end
   end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register busy bit and ROB tag,
// NRD combinational read ports, single-cycle flush and a registered busy count.
// Optional feature: REGFILE_COMMIT_BYPASS_EN enables same-cycle commit bypass.
module reg_rename_file
   import reg_rename_file_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREG  = 32,
   parameter int unsigned ROB_W = 4,
   parameter int unsigned NRD   = 2,
   parameter int unsigned RW    = $clog2(NREG),
   parameter int unsigned CW    = $clog2(NREG) + 1
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 rdy_in,
   input  logic                 disp_en_in,
   input  logic [RW-1:0]        disp_rd_in,
   input  logic [ROB_W-1:0]     disp_tag_in,
   input  logic [NRD*RW-1:0]    rs_in,
   output logic [NRD*XLEN-1:0]  val_out,
   output logic [NRD-1:0]       busy_out,
   output logic [NRD*ROB_W-1:0] tag_out,
   input  logic                 com_en_in,
   input  logic [RW-1:0]        com_rd_in,
   input  logic [XLEN-1:0]      com_val_in,
   input  logic [ROB_W-1:0]     com_tag_in,
   input  logic                 flush_in,
   output logic [CW-1:0]        busy_cnt_out
);

   logic [XLEN-1:0]  val_q [NREG];
   logic [XLEN-1:0]  val_d [NREG];
   logic [ROB_W-1:0] tag_q [NREG];
   logic [ROB_W-1:0] tag_d [NREG];
   logic [NREG-1:0]  busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic com_wr, com_clr, disp_set, cnt_inc, cnt_dec;

   // Decode which updates take effect this edge (x0 is never written or renamed).
   always_comb begin
      com_wr   = com_en_in && (com_rd_in != RW'(RegZero));
      com_clr  = com_wr && busy_q[com_rd_in] && (tag_q[com_rd_in] == com_tag_in);
      disp_set = disp_en_in && (disp_rd_in != RW'(RegZero));
      // Re-renaming a busy register, or dispatch onto the register being
      // cleared, leaves the population unchanged.
      cnt_inc  = disp_set && !busy_q[disp_rd_in];
      cnt_dec  = com_clr && !(disp_set && (disp_rd_in == com_rd_in));
   end

   // Next-state for values, rename state and busy count.
   always_comb begin
      val_d  = val_q;
      tag_d  = tag_q;
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (rdy_in) begin
         if (com_wr) begin
            val_d[com_rd_in] = com_val_in;
         end
         if (flush_in) begin
            busy_d = '0;
            for (int i = 0; i < int'(NREG); i++) begin
               tag_d[i] = ROB_W'(TagRst);
            end
            cnt_d = '0;
         end else begin
            if (com_clr) begin
               busy_d[com_rd_in] = 1'b0;
               tag_d[com_rd_in]  = ROB_W'(TagRst);
            end
            // Dispatch wins over a same-register commit clear.
            if (disp_set) begin
               busy_d[disp_rd_in] = 1'b1;
               tag_d[disp_rd_in]  = disp_tag_in;
            end
            cnt_d = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < int'(NREG); i++) begin
            val_q[i] <= XLEN'(DataRst);
            tag_q[i] <= ROB_W'(TagRst);
         end
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         val_q  <= val_d;
         tag_q  <= tag_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_cnt_out = cnt_q;

   for (genvar p = 0; p < int'(NRD); p++) begin : g_rd
      reg_read_port #(
         .XLEN  (XLEN),
         .NREG  (NREG),
         .ROB_W (ROB_W),
         .RW    (RW)
      ) u_port (
         .rst_n_in   (rst_n_in),
         .rs_in      (rs_in[p*RW +: RW]),
         .vals_in    (val_q),
         .busy_in    (busy_q),
         .tags_in    (tag_q),
         .com_en_in  (com_en_in),
         .com_rd_in  (com_rd_in),
         .com_val_in (com_val_in),
         .com_tag_in (com_tag_in),
         .val_out    (val_out[p*XLEN +: XLEN]),
         .busy_out   (busy_out[p]),
         .tag_out    (tag_out[p*ROB_W +: ROB_W])
      );
   end

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file; expectations follow REGFILE_COMMIT_BYPASS_EN.
module tb_reg_rename_file;

   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int ROB_W = 4;
   localparam int NRD   = 2;
   localparam int RW    = 5;
   localparam int CW    = 6;

`ifdef REGFILE_COMMIT_BYPASS_EN
   localparam bit Byp = 1'b1;
`else
   localparam bit Byp = 1'b0;
`endif

   logic                 clk_in = 1'b0;
   logic                 rst_n_in, rdy_in, disp_en_in, com_en_in, flush_in;
   logic [RW-1:0]        disp_rd_in, com_rd_in;
   logic [ROB_W-1:0]     disp_tag_in, com_tag_in;
   logic [XLEN-1:0]      com_val_in;
   logic [NRD*RW-1:0]    rs_in;
   logic [NRD*XLEN-1:0]  val_out;
   logic [NRD-1:0]       busy_out;
   logic [NRD*ROB_W-1:0] tag_out;
   logic [CW-1:0]        busy_cnt_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_in = ~clk_in;

   reg_rename_file #(
      .XLEN  (XLEN),
      .NREG  (NREG),
      .ROB_W (ROB_W),
      .NRD   (NRD)
   ) dut (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .rdy_in       (rdy_in),
      .disp_en_in   (disp_en_in),
      .disp_rd_in   (disp_rd_in),
      .disp_tag_in  (disp_tag_in),
      .rs_in        (rs_in),
      .val_out      (val_out),
      .busy_out     (busy_out),
      .tag_out      (tag_out),
      .com_en_in    (com_en_in),
      .com_rd_in    (com_rd_in),
      .com_val_in   (com_val_in),
      .com_tag_in   (com_tag_in),
      .flush_in     (flush_in),
      .busy_cnt_out (busy_cnt_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic port(input string tag, input int p, input logic [31:0] v,
                       input logic b, input logic [3:0] t);
      chk({tag, ".val"},  val_out[p*XLEN +: XLEN], v);
      chk({tag, ".busy"}, 32'(busy_out[p]), 32'(b));
      chk({tag, ".tag"},  32'(tag_out[p*ROB_W +: ROB_W]), 32'(t));
   endtask

   task automatic rd(input logic [4:0] r0, input logic [4:0] r1);
      rs_in = {r1, r0};
      #1;
   endtask

   task automatic disp(input logic [4:0] r, input logic [3:0] t);
      disp_en_in = 1'b1; disp_rd_in = r; disp_tag_in = t;
   endtask

   task automatic com(input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
      com_en_in = 1'b1; com_rd_in = r; com_tag_in = t; com_val_in = v;
      #1;
   endtask

   // Take one edge, then drop the one-shot requests and let reads settle.
   task automatic tick();
      @(posedge clk_in);
      #1;
      disp_en_in = 1'b0; com_en_in = 1'b0; flush_in = 1'b0;
      #1;
   endtask

   initial begin
      rst_n_in = 1'b0; rdy_in = 1'b1; disp_en_in = 1'b0; com_en_in = 1'b0;
      flush_in = 1'b0; disp_rd_in = '0; disp_tag_in = '0; com_rd_in = '0;
      com_tag_in = '0; com_val_in = '0; rs_in = '0;
      #12 rst_n_in = 1'b1;
      rd(5, 5);
      port("rst.p0", 0, 0, 0, 0);
      port("rst.p1", 1, 0, 0, 0);
      chk("rst.cnt", 32'(busy_cnt_out), 0);

      // Dispatch x5 tag 3; not visible until after the edge.
      disp(5, 3); #1;
      chk("disp.same_cycle.busy", 32'(busy_out[0]), 0);
      tick();
      port("disp.x5", 0, 0, 1, 3);
      chk("disp.cnt", 32'(busy_cnt_out), 1);

      // Re-rename x5 to tag 7: count stays 1.
      disp(5, 7); tick();
      port("rerename.x5", 1, 0, 1, 7);
      chk("rerename.cnt", 32'(busy_cnt_out), 1);

      // Stale commit (tag 3): value lands, rename state kept.
      com(5, 3, 32'hAA);
      port("stale.same", 0, Byp ? 32'hAA : 32'h0, 1, 7);
      tick();
      port("stale.after", 0, 32'hAA, 1, 7);
      chk("stale.cnt", 32'(busy_cnt_out), 1);

      // Matching commit (tag 7) frees x5.
      com(5, 7, 32'hBB);
      port("match.same", 0, Byp ? 32'hBB : 32'hAA, !Byp, Byp ? 4'd0 : 4'd7);
      tick();
      port("match.after", 0, 32'hBB, 0, 0);
      chk("match.cnt", 32'(busy_cnt_out), 0);

      // Bypass case on port 1: x6 busy tag 2, commit 0x1234.
      disp(6, 2); tick();
      rd(5, 6);
      com(6, 2, 32'h1234);
      port("byp.p1", 1, Byp ? 32'h1234 : 32'h0, !Byp, Byp ? 4'd0 : 4'd2);
      port("byp.p0", 0, 32'hBB, 0, 0);
      tick();
      port("byp.after", 1, 32'h1234, 0, 0);
      chk("byp.cnt", 32'(busy_cnt_out), 0);

      // rdy low freezes state.
      rdy_in = 1'b0;
      disp(7, 1); tick();
      rdy_in = 1'b1;
      rd(7, 7);
      port("frozen.x7", 0, 0, 0, 0);
      chk("frozen.cnt", 32'(busy_cnt_out), 0);

      // Rename x1..x3, then flush with a same-cycle dispatch and commit.
      disp(1, 1); tick();
      disp(2, 2); tick();
      disp(3, 3); tick();
      chk("three.cnt", 32'(busy_cnt_out), 3);
      rd(1, 2);
      flush_in = 1'b1; disp(4, 5); com(1, 1, 32'd9);
      port("flush.same.x1", 0, Byp ? 32'd9 : 32'd0, !Byp, Byp ? 4'd0 : 4'd1);
      port("flush.same.x2", 1, 0, 1, 2);
      tick();
      port("flush.x1", 0, 9, 0, 0);
      port("flush.x2", 1, 0, 0, 0);
      rd(4, 3);
      port("flush.x4", 0, 0, 0, 0);
      port("flush.x3", 1, 0, 0, 0);
      chk("flush.cnt", 32'(busy_cnt_out), 0);

      // Dispatch and commit-clear on the same register: net count 0.
      disp(8, 4); tick();
      chk("same.pre.cnt", 32'(busy_cnt_out), 1);
      disp(8, 6); com(8, 4, 32'h55); tick();
      rd(8, 8);
      port("same.x8", 0, 32'h55, 1, 6);
      chk("same.cnt", 32'(busy_cnt_out), 1);

      // x0 is hard-wired, even during a commit to it.
      rd(0, 0);
      disp(0, 5); com(0, 0, 32'hFF);
      port("x0.same", 1, 0, 0, 0);
      tick();
      port("x0.p0", 0, 0, 0, 0);
      port("x0.p1", 1, 0, 0, 0);
      chk("x0.cnt", 32'(busy_cnt_out), 1);

      // Asynchronous reset mid-stream.
      rd(8, 8);
      @(negedge clk_in);
      rst_n_in = 1'b0; #1;
      port("arst.p0", 0, 0, 0, 0);
      chk("arst.cnt", 32'(busy_cnt_out), 0);
      rst_n_in = 1'b1; #1;
      port("arst.after", 1, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
